bcd_scan_ctrl: RTL and testbench
================================

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst_a_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit, scan enable; low forces the display off.
REQ-005 SHALL have port load, input, 1 bit, one-cycle request to display value_in.
REQ-006 SHALL have port value_in, input, 16 bits, four BCD digits; [3:0] is digit 0 (least significant).
REQ-007 SHALL have port blank_lz, input, 1 bit, enables leading-zero blanking; sampled with load.
REQ-008 SHALL have port bcd_out, output, 4 bits, nibble driven to the shared BCD-to-7-segment decoder.
REQ-009 SHALL have port dig_sel, output, 4 bits, active-low one-hot digit enable; 4'b1111 means all digits off.
REQ-010 SHALL have port load_ack, output, 1 bit, one-cycle pulse when the pending value is committed to the shadow register.

Function
REQ-011 SHALL implement the states OFF, GUARD and ACTIVE, plus a 2-bit digit index (idx) and a prescaler count (pcnt, 0..DIV-1).
REQ-012 SHALL hold dig_sel=4'b1111 in OFF and GUARD; in ACTIVE it SHALL drive dig_sel bit idx low and all other bits high.
REQ-013 SHALL spend each digit slot as 1 GUARD cycle followed by DIV-1 ACTIVE cycles, giving a frame of 4*DIV cycles.
REQ-014 SHALL advance idx 0->1->2->3->0 (wrap) on the last ACTIVE cycle (pcnt==DIV-1); the next cycle SHALL be GUARD for the new idx.
REQ-015 SHALL update bcd_out in GUARD to shadow digit idx, registered, and hold it stable for the rest of the slot.
REQ-016 SHALL capture value_in and blank_lz into a pending register on load; a second load before commit SHALL overwrite the pending value, and only one load_ack SHALL follow.
REQ-017 SHALL, in SCAN, commit pending to shadow only at the frame boundary (idx 3->0 transition) and pulse load_ack in that same cycle; there SHALL be no tearing within a frame.
REQ-018 SHALL, in OFF with en=1, commit a pending load on the next cycle, pulse load_ack, and enter GUARD with idx=0 and pcnt=0.
REQ-019 SHALL remain in OFF while no load has ever been committed, even when en=1.
REQ-020 SHALL, when en falls, go to OFF on the next cycle from any state, clear idx and pcnt, and retain shadow and pending.
REQ-021 SHALL, when en rises with a valid shadow, enter GUARD with idx=0; if a pending value exists, it SHALL be committed first per REQ-018.
REQ-022 SHALL blank a digit k (k=3..1) when blank_lz=1, shadow digit k==0 and all digits above k are 0: dig_sel stays 4'b1111 for that whole slot; digit 0 is never blanked.
REQ-023 SHALL drive bcd_out=4'hF (decoder blank code) for any shadow nibble greater than 9, while dig_sel still enables that digit.
REQ-024 SHALL, when load and the frame boundary coincide, commit the previous pending value and retain the new value as pending for the next boundary.

Reset
REQ-025 SHALL, while rst_a_n=0, asynchronously force state=OFF, idx=0, pcnt=0, dig_sel=4'b1111, bcd_out=4'h0, load_ack=0, shadow invalid and zero, and no pending value.
REQ-026 SHALL release reset synchronously to clk; the first transition out of OFF occurs no earlier than the first edge after release.
REQ-027 SHALL, on reset mid-frame, drop any pending load without issuing load_ack.

Structure
REQ-028 SHALL place the state enum {OFF, GUARD, ACTIVE}, N_DIG=4 and BLANK_CODE=4'hF in shared package bcd_scan_pkg.
REQ-029 SHALL place the prescaler (pcnt plus last-cycle flag, clear input) in sub-module scan_prescaler; all other logic stays in bcd_scan_ctrl.

Verification (DIV=4)
REQ-030 SHALL cover: reset, en=1, load value_in=16'h1234 -> load_ack 1 cycle later, then a repeating frame of 16 cycles in which dig_sel goes 1111,1110x3,1111,1101x3,... and bcd_out=4,3,2,1.
REQ-031 SHALL cover: blank_lz=1, value 16'h0070 -> digits 3 and 2 off for their full slots; digit 1 shows 7, digit 0 shows 0; with blank_lz=0, all four digits are lit.
REQ-032 SHALL cover: load 16'h5678 mid-frame, then load 16'h9999 before the boundary -> a single load_ack at the idx 3->0 transition, and the next frame shows 9999.
REQ-033 SHALL cover: value 16'h00A1 -> digit 1 bcd_out=4'hF with its dig_sel bit low.
REQ-034 SHALL cover: en dropped during digit 2 -> dig_sel=4'b1111 next cycle; en restored -> GUARD with idx=0 and the same shadow contents.
REQ-035 SHALL cover: rst_a_n pulsed low mid-slot, asynchronously between clock edges -> outputs hit reset values immediately, no load_ack, and OFF after release.

Source files
------------

// File: rtl/bcd_scan_pkg.sv
// Shared types and helpers for the multiplexed BCD display scanner.
// Digit extraction, blank-code mapping and leading-zero test live here.
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    OFF,
    GUARD,
    ACTIVE
  } state_t;

  localparam int N_DIG = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int PCNT_W = 16;
  localparam logic [3:0] ALL_OFF = 4'b1111;

  typedef struct packed {
    logic [15:0] val;
    logic        blz;
  } disp_t;

  function automatic logic [3:0] nib(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    return v[{k, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] seg_code(
    input logic [3:0] d
  );
    return (d > 4'd9) ? BLANK_CODE : d;
  endfunction

  // Digit k is a leading zero when it and all digits above it are zero.
  function automatic logic lz_blank(
    input disp_t      s,
    input logic [1:0] k
  );
    logic [15:0] hi;
    hi = s.val >> {k, 2'b00};
    return s.blz && (k != 2'd0) && (hi == 16'h0000);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 and flags the final cycle of a slot.
// Held at zero while clr is asserted.
module scan_prescaler
  import bcd_scan_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic last
);

  localparam logic [PCNT_W-1:0] TOP = PCNT_W'(DIV - 1);

  logic [PCNT_W-1:0] pcnt;

  assign last = (pcnt == TOP);

  // Free-running slot counter, wraps on the last cycle of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr || last) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Four-digit multiplexed BCD scanner with guard cycles, frame-aligned
// shadow commit and optional leading-zero blanking.
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_a_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic [3:0]  dig_sel,
  output logic        load_ack
);

  state_t     state;
  logic [1:0] idx;
  disp_t      shadow;
  disp_t      pend;
  logic       sh_ok;
  logic       pd_ok;

  logic       last;
  logic       clr;
  logic       frame_end;
  logic       wake;
  logic       commit;
  disp_t      view;

  assign clr       = !en || (state == OFF);
  assign frame_end = (state == ACTIVE) && last && (idx == 2'd3);
  assign wake      = (state == OFF) && (pd_ok || sh_ok);
  assign commit    = en && pd_ok && (frame_end || (state == OFF));
  assign view      = commit ? pend : shadow;

  scan_prescaler #(
    .DIV (DIV)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_a_n),
    .clr   (clr),
    .last  (last)
  );

  // Pending/shadow bookkeeping plus the scan FSM with registered outputs
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state    <= OFF;
      idx      <= '0;
      shadow   <= '0;
      sh_ok    <= 1'b0;
      pend     <= '0;
      pd_ok    <= 1'b0;
      bcd_out  <= 4'h0;
      dig_sel  <= ALL_OFF;
      load_ack <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (commit) begin
        shadow   <= pend;
        sh_ok    <= 1'b1;
        pd_ok    <= 1'b0;
        load_ack <= 1'b1;
      end
      if (load) begin
        pend  <= '{val: value_in, blz: blank_lz};
        pd_ok <= 1'b1;
      end
      if (!en) begin
        state   <= OFF;
        idx     <= '0;
        dig_sel <= ALL_OFF;
      end else begin
        unique case (state)
          OFF: begin
            if (wake) begin
              state   <= GUARD;
              idx     <= '0;
              dig_sel <= ALL_OFF;
              bcd_out <= seg_code(nib(view.val, 2'd0));
            end
          end
          GUARD: begin
            state <= ACTIVE;
            if (lz_blank(shadow, idx)) begin
              dig_sel <= ALL_OFF;
            end else begin
              dig_sel <= ~(4'b0001 << idx);
            end
          end
          ACTIVE: begin
            if (last) begin
              state   <= GUARD;
              idx     <= idx + 2'd1;
              dig_sel <= ALL_OFF;
              bcd_out <= seg_code(nib(view.val, idx + 2'd1));
            end
          end
          default: begin
            state <= OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with a frame-position reference model.
// Outputs are compared every falling edge, plus literal spot checks.
module tb_bcd_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst_a_n;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel;
  logic        load_ack;

  int n_err = 0;
  int n_chk = 0;
  bit go = 0;

  bcd_scan_ctrl #(
    .DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst_a_n  (rst_a_n),
    .en       (en),
    .load     (load),
    .value_in (value_in),
    .blank_lz (blank_lz),
    .bcd_out  (bcd_out),
    .dig_sel  (dig_sel),
    .load_ack (load_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: display on/off, position within the frame,
  // shadow and pending values.
  bit          m_on   = 0;
  int          m_pos  = 0;
  logic [15:0] m_sh   = 16'h0;
  bit          m_shz  = 0;
  bit          m_shok = 0;
  logic [15:0] m_pd   = 16'h0;
  bit          m_pdz  = 0;
  bit          m_pdok = 0;
  bit          m_ack  = 0;
  logic [3:0]  m_bcd  = 4'h0;

  function automatic int digit(input int k);
    return int'((m_sh >> (4 * k)) & 16'hF);
  endfunction

  function automatic bit blanked(input int k);
    return (k > 0) && m_shz && ((m_sh >> (4 * k)) == 16'h0);
  endfunction

  task automatic m_commit();
    m_sh   = m_pd;
    m_shz  = m_pdz;
    m_shok = 1;
    m_pdok = 0;
    m_ack  = 1;
  endtask

  initial forever begin
    int d;
    @(posedge clk or negedge rst_a_n);
    if (!rst_a_n) begin
      m_on = 0; m_pos = 0; m_sh = 16'h0; m_shz = 0; m_shok = 0;
      m_pdok = 0; m_ack = 0; m_bcd = 4'h0;
    end else begin
      m_ack = 0;
      if (!en) begin
        m_on = 0;
        m_pos = 0;
      end else if (!m_on) begin
        if (m_pdok) begin
          m_commit();
          m_on = 1;
          m_pos = 0;
        end else if (m_shok) begin
          m_on = 1;
          m_pos = 0;
        end
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0 && m_pdok) m_commit();
      end
      if (load) begin
        m_pd = value_in;
        m_pdz = blank_lz;
        m_pdok = 1;
      end
      if (m_on) begin
        d = digit(m_pos / DIV);
        m_bcd = (d > 9) ? 4'hF : 4'(d);
      end
    end
  end

  initial forever begin
    logic [3:0] e_dig;
    int slot;
    @(negedge clk);
    if (go) begin
      e_dig = 4'hF;
      if (m_on) begin
        slot = m_pos / DIV;
        if ((m_pos % DIV) != 0 && !blanked(slot))
          e_dig = ~(4'b0001 << slot);
      end
      chk("dig_sel", dig_sel, e_dig);
      chk("bcd_out", bcd_out, m_bcd);
      chk("load_ack", {3'b0, load_ack}, {3'b0, m_ack});
    end
  end

  task automatic do_load(input logic [15:0] v, input logic z);
    value_in = v;
    blank_lz = z;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cyc(1);
      if (load_ack) begin
        seen = 1;
        break;
      end
    end
    chk_i(nm, int'(seen), 1);
  endtask

  initial begin
    int acks;
    rst_a_n = 1'b1;
    en = 1'b0;
    load = 1'b0;
    value_in = 16'h0;
    blank_lz = 1'b0;
    #1 rst_a_n = 1'b0;
    go = 1;
    cyc(2);
    chk("rst_dig", dig_sel, 4'hF);
    chk("rst_bcd", bcd_out, 4'h0);
    chk("rst_ack", {3'b0, load_ack}, 4'h0);
    rst_a_n = 1'b1;
    cyc(3);
    en = 1'b1;
    cyc(3);
    chk("no_shadow_off", dig_sel, 4'hF);

    // Basic scan of 1234
    do_load(16'h1234, 1'b0);
    chk("ack_not_yet", {3'b0, load_ack}, 4'h0);
    cyc(1);
    chk("ack_1234", {3'b0, load_ack}, 4'h1);
    chk("g0_dig", dig_sel, 4'hF);
    chk("g0_bcd", bcd_out, 4'h4);
    cyc(1);
    chk("a0_dig", dig_sel, 4'hE);
    chk("a0_ack", {3'b0, load_ack}, 4'h0);
    cyc(3);
    chk("g1_dig", dig_sel, 4'hF);
    chk("g1_bcd", bcd_out, 4'h3);
    cyc(1);
    chk("a1_dig", dig_sel, 4'hD);
    cyc(40);

    // Leading-zero blanking of 0070
    en = 1'b0;
    cyc(1);
    chk("en_off_dig", dig_sel, 4'hF);
    do_load(16'h0070, 1'b1);
    en = 1'b1;
    cyc(1);
    chk("ack_0070", {3'b0, load_ack}, 4'h1);
    chk("lz_g0_bcd", bcd_out, 4'h0);
    cyc(5);
    chk("lz_d1_dig", dig_sel, 4'hD);
    chk("lz_d1_bcd", bcd_out, 4'h7);
    cyc(4);
    chk("lz_d2_dig", dig_sel, 4'hF);
    cyc(4);
    chk("lz_d3_dig", dig_sel, 4'hF);
    cyc(4);
    chk("lz_d0_dig", dig_sel, 4'hE);
    do_load(16'h0070, 1'b0);
    cyc(39);

    // Double load before the boundary
    do_load(16'h5678, 1'b0);
    cyc(2);
    do_load(16'h9999, 1'b0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (load_ack) begin
        acks++;
        chk("dbl_bcd", bcd_out, 4'h9);
      end
    end
    chk_i("dbl_ack_cnt", acks, 1);

    // Non-decimal nibble and en drop during digit 2
    do_load(16'h00A1, 1'b0);
    wait_ack("ack_00a1");
    cyc(5);
    chk("hex_dig", dig_sel, 4'hD);
    chk("hex_bcd", bcd_out, 4'hF);
    cyc(4);
    chk("d2_dig", dig_sel, 4'hB);
    en = 1'b0;
    cyc(1);
    chk("drop_dig", dig_sel, 4'hF);
    cyc(3);
    en = 1'b1;
    cyc(1);
    chk("wake_dig", dig_sel, 4'hF);
    chk("wake_bcd", bcd_out, 4'h1);
    chk("wake_ack", {3'b0, load_ack}, 4'h0);
    cyc(1);
    chk("wake_a0", dig_sel, 4'hE);
    cyc(20);

    // Asynchronous reset mid-slot with a load pending
    do_load(16'h4321, 1'b0);
    cyc(2);
    #3;
    rst_a_n = 1'b0;
    #1;
    chk("arst_dig", dig_sel, 4'hF);
    chk("arst_bcd", bcd_out, 4'h0);
    chk("arst_ack", {3'b0, load_ack}, 4'h0);
    cyc(2);
    rst_a_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (load_ack) acks++;
    end
    chk_i("arst_no_ack", acks, 0);
    chk("arst_off", dig_sel, 4'hF);

    do_load(16'h0009, 1'b1);
    wait_ack("ack_0009");
    cyc(1);
    chk("last_a0", dig_sel, 4'hE);
    chk("last_bcd", bcd_out, 4'h9);
    cyc(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
